// File: rtl/phy_rx_pkg.sv
// ---------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the multilane PHY receiver:
//   - lane_state_e    : per-lane alignment FSM states (SEARCH, ALIGN, LOCKED)
//   - DEFAULT_COMMA   : default alignment / idle byte (K28.5-style 8'hBC)
//   - groups_per_word : number of lane groups that make up one output word
// ---------------------------------------------------------------------------
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } lane_state_e;

    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

    // One group carries one byte from every lane.
    function automatic int groups_per_word(input int word_w, input int lanes);
        return word_w / (8 * lanes);
    endfunction

endpackage

// File: rtl/phy_rx_lane_align.sv
// ---------------------------------------------------------------------------
// phy_rx_lane_align
// Byte aligner for a single serial lane. Hunts for the comma byte at any bit
// offset, confirms it on LOCK_CNT consecutive byte boundaries, then emits one
// byte per boundary together with a comma flag.
// Ports:
//   clk_32f    in   bit-rate clock
//   reset      in   synchronous active-high reset
//   serial_in  in   serial data, MSB of each byte first
//   locked     out  lane has achieved byte lock (sticky until reset)
//   byte_out   out  last byte captured at a boundary (held)
//   is_comma   out  byte_out equals the comma byte
//   boundary   out  one-cycle strobe: byte_out/is_comma just updated
// ---------------------------------------------------------------------------
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA    = DEFAULT_COMMA,
    parameter int         LOCK_CNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic       locked,
    output logic [7:0] byte_out,
    output logic       is_comma,
    output logic       boundary
);

    localparam logic [1:0] SEARCH = ST_SEARCH;
    localparam logic [1:0] ALIGN  = ST_ALIGN;
    localparam logic [1:0] LOCKED = ST_LOCKED;

    logic [7:0] sr_q, sr_d;
    logic [1:0] state_q, state_d;
    logic [2:0] bitc_q, bitc_d;
    logic [2:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       is_comma_q, is_comma_d;
    logic       boundary_q, boundary_d;

    always_comb begin
        sr_d       = {sr_q[6:0], serial_in};
        state_d    = state_q;
        // bitc wraps 7 -> 0 on its own; a boundary is the edge where it wraps
        bitc_d     = bitc_q + 3'd1;
        bc_cnt_d   = bc_cnt_q;
        byte_d     = byte_q;
        is_comma_d = is_comma_q;
        boundary_d = 1'b0;

        case (state_q)
            SEARCH: begin
                // The edge that completes a comma is itself a boundary
                if (sr_d == COMMA) begin
                    bitc_d   = 3'd0;
                    bc_cnt_d = 3'd1;
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                if (bitc_q == 3'd7) begin
                    if (sr_d == COMMA) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                        if (bc_cnt_q + 3'd1 == 3'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        bc_cnt_d = 3'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (bitc_q == 3'd7) begin
                    byte_d     = sr_d;
                    is_comma_d = (sr_d == COMMA);
                    boundary_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q       <= 8'h00;
            state_q    <= SEARCH;
            bitc_q     <= 3'd0;
            bc_cnt_q   <= 3'd0;
            byte_q     <= 8'h00;
            is_comma_q <= 1'b0;
            boundary_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            state_q    <= state_d;
            bitc_q     <= bitc_d;
            bc_cnt_q   <= bc_cnt_d;
            byte_q     <= byte_d;
            is_comma_q <= is_comma_d;
            boundary_q <= boundary_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign byte_out = byte_q;
    assign is_comma = is_comma_q;
    assign boundary = boundary_q;

endmodule

// File: rtl/phy_rx_multilane.sv
// ---------------------------------------------------------------------------
// phy_rx_multilane
// LANES-wide serial receiver. Each lane aligns independently on the comma
// byte; once every lane is locked, byte groups are striped into WORD_W-bit
// words (first group in the MSBs, lane 0 most significant within a group).
// Ports:
//   clk_32f      in   bit-rate clock
//   reset        in   synchronous active-high reset
//   serial_in    in   bit i = lane i serial data
//   salida       out  last assembled word, held between strobes
//   valid_out    out  one-cycle strobe: salida holds a new word
//   lane_locked  out  per-lane lock status
//   active       out  all lanes locked
//   err          out  one-cycle strobe: mixed comma/data group while active
// ---------------------------------------------------------------------------
module phy_rx_multilane
    import phy_rx_pkg::*;
#(
    parameter int         LANES    = 2,
    parameter int         WORD_W   = 32,
    parameter logic [7:0] COMMA    = DEFAULT_COMMA,
    parameter int         LOCK_CNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [LANES-1:0]  serial_in,
    output logic [WORD_W-1:0] salida,
    output logic              valid_out,
    output logic [LANES-1:0]  lane_locked,
    output logic              active,
    output logic              err
);

    localparam int GW     = 8 * LANES;
    localparam int G      = groups_per_word(WORD_W, LANES);
    localparam int SLOT_W = (G > 1) ? $clog2(G) : 1;

    logic [7:0]       lane_byte [LANES];
    logic [LANES-1:0] lane_is_comma;
    logic [LANES-1:0] lane_boundary;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_rx_lane_align #(
            .COMMA    (COMMA),
            .LOCK_CNT (LOCK_CNT)
        ) u_align (
            .clk_32f   (clk_32f),
            .reset     (reset),
            .serial_in (serial_in[i]),
            .locked    (lane_locked[i]),
            .byte_out  (lane_byte[i]),
            .is_comma  (lane_is_comma[i]),
            .boundary  (lane_boundary[i])
        );
    end

    // Lanes are skew-free, so only lane 0 times the groups; the remaining
    // strobes are redundant and deliberately left unused.
    logic unused_boundaries;
    assign unused_boundaries = ^lane_boundary;

    assign active = &lane_locked;

    logic [GW-1:0]     group;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] salida_q, salida_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_comb begin
        group = '0;
        for (int i = 0; i < LANES; i++) begin
            group[GW-1-8*i -: 8] = lane_byte[i];
        end
    end

    always_comb begin
        slot_d   = slot_q;
        word_d   = word_q;
        salida_d = salida_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (active && lane_boundary[0]) begin
            if (&lane_is_comma) begin
                // Idle group: keeps any partial word intact
                slot_d = slot_q;
            end else if (~|lane_is_comma) begin
                for (int s = 0; s < G; s++) begin
                    if (slot_q == SLOT_W'(s)) begin
                        word_d[WORD_W-1-s*GW -: GW] = group;
                    end
                end
                if (slot_q == SLOT_W'(G - 1)) begin
                    salida_d = word_d;
                    valid_d  = 1'b1;
                    slot_d   = '0;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end else begin
                // Stale slots are overwritten by the next word, so only the
                // pointer needs to restart
                err_d  = 1'b1;
                slot_d = '0;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            slot_q   <= '0;
            word_q   <= '0;
            salida_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            word_q   <= word_d;
            salida_q <= salida_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign salida    = salida_q;
    assign valid_out = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_phy_rx_multilane.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_multilane
// Directed bench for phy_rx_multilane with default parameters (2 lanes,
// 32-bit words, comma 8'hBC, lock after 4 commas).
// ---------------------------------------------------------------------------
module tb_phy_rx_multilane;

    logic        clk_32f;
    logic        reset;
    logic [1:0]  serial_in;
    logic [31:0] salida;
    logic        valid_out;
    logic [1:0]  lane_locked;
    logic        active;
    logic        err;

    int checks;
    int errors;
    int valid_count;
    int err_count;

    phy_rx_multilane dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .serial_in   (serial_in),
        .salida      (salida),
        .valid_out   (valid_out),
        .lane_locked (lane_locked),
        .active      (active),
        .err         (err)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Pulse counters sampled mid-cycle, away from the active edge
    always @(negedge clk_32f) begin
        if (valid_out) valid_count++;
        if (err) err_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Shift one byte into each lane, MSB first; returns just after the edge
    // that samples the last bit.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk_32f);
            serial_in = {b1[k], b0[k]};
            @(posedge clk_32f);
        end
    endtask

    // Run alongside the next applyStimulus: verifies the 1-cycle latency and
    // single-cycle width of valid_out (want_err=0) or err (want_err=1).
    task automatic checkPulse(input string tag, input logic [31:0] exp_word, input bit want_err);
        #1;
        checkOutput({tag, "_early"}, want_err ? err : valid_out, 32'd0);
        @(posedge clk_32f);
        #1;
        checkOutput({tag, "_pulse"}, want_err ? err : valid_out, 32'd1);
        if (!want_err) checkOutput({tag, "_word"}, salida, exp_word);
        @(posedge clk_32f);
        #1;
        checkOutput({tag, "_width"}, want_err ? err : valid_out, 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        valid_count = 0;
        err_count   = 0;
        reset       = 1'b1;
        serial_in   = 2'b00;

        // Reset held with random line activity
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_32f);
            serial_in = 2'($urandom_range(0, 3));
            @(posedge clk_32f);
            #1;
            checkOutput("rst_salida", salida, 32'd0);
            checkOutput("rst_flags", {27'd0, valid_out, err, active, lane_locked}, 32'd0);
        end
        @(negedge clk_32f);
        reset     = 1'b0;
        serial_in = 2'b00;
        @(posedge clk_32f);
        #1;
        checkOutput("rel_salida", salida, 32'd0);
        checkOutput("rel_flags", {27'd0, valid_out, err, active, lane_locked}, 32'd0);

        // Lock after exactly four commas, then one word
        repeat (3) applyStimulus(8'hBC, 8'hBC);
        #1;
        checkOutput("a_lock3", {30'd0, lane_locked}, 32'd0);
        applyStimulus(8'hBC, 8'hBC);
        #1;
        checkOutput("a_lock4", {30'd0, lane_locked}, 32'd3);
        checkOutput("a_active", {31'd0, active}, 32'd1);
        applyStimulus(8'hAA, 8'h11);
        applyStimulus(8'hBB, 8'h22);
        fork
            applyStimulus(8'hBC, 8'hBC);
            checkPulse("a_word", 32'hAA11BB22, 1'b0);
        join
        checkOutput("a_vcount", valid_count, 32'd1);
        checkOutput("a_ecount", err_count, 32'd0);

        // Reset after one data group: clears everything, lock must be regained
        applyStimulus(8'h01, 8'h02);
        @(negedge clk_32f);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        checkOutput("b_rst_salida", salida, 32'd0);
        checkOutput("b_rst_flags", {27'd0, valid_out, err, active, lane_locked}, 32'd0);
        @(negedge clk_32f);
        reset = 1'b0;
        applyStimulus(8'h03, 8'h04);
        applyStimulus(8'h05, 8'h06);
        checkOutput("b_nolock", {30'd0, lane_locked}, 32'd0);
        checkOutput("b_vcount", valid_count, 32'd1);

        // Three commas then data: alignment abandoned; four commas relock
        repeat (3) applyStimulus(8'hBC, 8'hBC);
        applyStimulus(8'h12, 8'h34);
        #1;
        checkOutput("c_lost", {30'd0, lane_locked}, 32'd0);
        checkOutput("c_vcount", valid_count, 32'd1);
        repeat (3) applyStimulus(8'hBC, 8'hBC);
        #1;
        checkOutput("c_lock3", {30'd0, lane_locked}, 32'd0);
        applyStimulus(8'hBC, 8'hBC);
        #1;
        checkOutput("c_lock4", {30'd0, lane_locked}, 32'd3);

        // Partial word 77/88 dropped by a mixed group; idle inside the word
        applyStimulus(8'h77, 8'h88);
        applyStimulus(8'hBC, 8'h55);
        fork
            applyStimulus(8'h01, 8'h02);
            checkPulse("e_err", 32'd0, 1'b1);
        join
        applyStimulus(8'hBC, 8'hBC);
        applyStimulus(8'h03, 8'h04);
        fork
            applyStimulus(8'hBC, 8'hBC);
            checkPulse("e_word", 32'h01020304, 1'b0);
        join
        checkOutput("e_vcount", valid_count, 32'd2);
        checkOutput("e_ecount", err_count, 32'd1);

        // Reset on the very edge a word would complete
        applyStimulus(8'hA1, 8'hB2);
        applyStimulus(8'hC3, 8'hD4);
        @(negedge clk_32f);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        checkOutput("f_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("f_salida", salida, 32'd0);
        checkOutput("f_locked", {30'd0, lane_locked}, 32'd0);

        // Three garbage bits before the commas: alignment at bit offset 3
        @(negedge clk_32f);
        reset     = 1'b0;
        serial_in = 2'b11;
        @(posedge clk_32f);
        @(negedge clk_32f);
        serial_in = 2'b00;
        @(posedge clk_32f);
        @(negedge clk_32f);
        serial_in = 2'b11;
        @(posedge clk_32f);
        repeat (4) applyStimulus(8'hBC, 8'hBC);
        #1;
        checkOutput("d_lock", {30'd0, lane_locked}, 32'd3);
        applyStimulus(8'hC3, 8'h5A);
        applyStimulus(8'h0F, 8'hF0);
        fork
            applyStimulus(8'hBC, 8'hBC);
            checkPulse("d_word", 32'hC35A0FF0, 1'b0);
        join
        checkOutput("d_vcount", valid_count, 32'd3);
        checkOutput("d_ecount", err_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
